// File: rtl/ped_request_ctrl_if.sv
// Handshake bundle between the pedestrian request front end and the traffic state machine.
// Purely combinational wiring: no latency, no backpressure beyond the grant level.
interface ped_request_ctrl_if;
  logic btn_in;
  logic tick_1Hz;
  logic grant;
  logic ped_req;
  logic wait_led;
  logic lockout;

  modport master (
    output btn_in, tick_1Hz, grant,
    input  ped_req, wait_led, lockout
  );

  modport slave (
    input  btn_in, tick_1Hz, grant,
    output ped_req, wait_led, lockout
  );
endinterface

// File: rtl/ped_request_ctrl.sv
// Pedestrian request front end: debounced button -> held request -> grant -> tick-counted lockout.
// Press-to-ped_req latency 2+DEBOUNCE_CYCLES cycles; request holds until grant. PED_REQ_MEMORY_EN keeps lockout presses.
module ped_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_W            = 20,
  parameter int LOCKOUT_SECS    = 10,
  parameter int LK_W            = 4
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  ped_request_ctrl_if.slave pif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_SERVING = 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  localparam logic [DB_W-1:0] DB_LAST = (DEBOUNCE_CYCLES > 0) ? DB_W'(DEBOUNCE_CYCLES - 1) : '0;
  localparam logic [LK_W-1:0] LK_LAST = (LOCKOUT_SECS > 0) ? LK_W'(LOCKOUT_SECS - 1) : '0;

  logic [1:0]      sync_q;
  logic            stable;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  logic [1:0]      state;
  logic [LK_W-1:0] lk_cnt;
  logic            lk_done;
  logic            ped_req_q;
  logic            wait_led_q;
  logic            lockout_q;
`ifdef PED_REQ_MEMORY_EN
  logic            memo;
`endif

  // Counter only runs while the synchronized level disagrees with the accepted level.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      sync_q <= '0;
      stable <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync_q <= {sync_q[0], pif.btn_in};
      if (sync_q[1] == stable) begin
        db_cnt <= '0;
      end else if (db_cnt >= DB_LAST) begin
        stable <= sync_q[1];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press   = sync_q[1] && !stable && (db_cnt >= DB_LAST);
  assign lk_done = (LOCKOUT_SECS == 0) || (pif.tick_1Hz && (lk_cnt >= LK_LAST));

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state      <= S_IDLE;
      lk_cnt     <= '0;
      ped_req_q  <= 1'b0;
      wait_led_q <= 1'b0;
      lockout_q  <= 1'b0;
`ifdef PED_REQ_MEMORY_EN
      memo       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (press) begin
            state      <= S_PENDING;
            ped_req_q  <= 1'b1;
            wait_led_q <= 1'b1;
          end
        end
        S_PENDING: begin
          // Grant takes priority over a coincident blink tick.
          if (pif.grant) begin
            state      <= S_SERVING;
            ped_req_q  <= 1'b0;
            wait_led_q <= 1'b0;
          end else if (pif.tick_1Hz) begin
            wait_led_q <= !wait_led_q;
          end
        end
        S_SERVING: begin
          if (!pif.grant) begin
            state     <= S_LOCKOUT;
            lk_cnt    <= '0;
            lockout_q <= 1'b1;
          end
        end
        S_LOCKOUT: begin
          if (lk_done) begin
            lockout_q <= 1'b0;
            lk_cnt    <= '0;
`ifdef PED_REQ_MEMORY_EN
            if (memo || press) begin
              state      <= S_PENDING;
              ped_req_q  <= 1'b1;
              wait_led_q <= 1'b1;
              memo       <= 1'b0;
            end else begin
              state      <= S_IDLE;
              wait_led_q <= 1'b0;
            end
`else
            state <= S_IDLE;
`endif
          end else begin
            if (pif.tick_1Hz && (lk_cnt < LK_LAST)) begin
              lk_cnt <= lk_cnt + 1'b1;
            end
`ifdef PED_REQ_MEMORY_EN
            if (press) begin
              memo       <= 1'b1;
              wait_led_q <= 1'b1;
            end
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pif.ped_req  = ped_req_q;
  assign pif.wait_led = wait_led_q;
  assign pif.lockout  = lockout_q;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Scoreboard bench for ped_request_ctrl: DEBOUNCE_CYCLES=4, LOCKOUT_SECS=3, tick_1Hz every 20 cycles.
module tb_ped_request_ctrl;
  logic clk_100MHz = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   tcnt   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  ped_request_ctrl_if pif();

  ped_request_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DB_W(20),
    .LOCKOUT_SECS(3),
    .LK_W(4)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .pif(pif)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Free-running 1 Hz stand-in: one-cycle pulse every 20 cycles, changed on the falling edge.
  initial begin
    pif.tick_1Hz = 1'b0;
    forever begin
      @(negedge clk_100MHz);
      tcnt = (tcnt == 19) ? 0 : tcnt + 1;
      pif.tick_1Hz = (tcnt == 19);
    end
  end

  function automatic exp_t mk(string t, logic [31:0] v);
    exp_t r;
    r.tag = t;
    r.val = v;
    return r;
  endfunction

  function automatic logic [31:0] outs();
    return {29'd0, pif.ped_req, pif.wait_led, pif.lockout};
  endfunction

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic apply_reset(int n);
    pif.btn_in = 1'b0;
    pif.grant  = 1'b0;
    reset      = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic press_wait(output int lat);
    lat = -1;
    pif.btn_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (pif.ped_req === 1'b1) begin
        lat = i;
        break;
      end
    end
    pif.btn_in = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] obs;
    sb.push_back(mk("reset_outs", 32'd0));
    sb.push_back(mk("idle_after_reset", 32'd0));
    apply_reset(3);
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    repeat (10) step();
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
  endtask

  task automatic test_bounce();
    exp_t e;
    logic [31:0] obs;
    int lat;
    int rises;
    logic prev;
    apply_reset(2);
    sb.push_back(mk("bounce_no_early_req", 32'd0));
    sb.push_back(mk("bounce_latency", 32'd6));
    sb.push_back(mk("bounce_press_count", 32'd1));
    rises = 0;
    for (int i = 0; i < 5; i++) begin
      pif.btn_in = 1'b1; step(); step();
      if (pif.ped_req === 1'b1) rises++;
      pif.btn_in = 1'b0; step(); step();
      if (pif.ped_req === 1'b1) rises++;
    end
    obs = {31'd0, pif.ped_req} | 32'(rises); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    pif.btn_in = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (pif.ped_req === 1'b1) begin lat = i; break; end
    end
    e = sb.pop_front(); checks++;
    if (lat < int'(e.val) - 1 || lat > int'(e.val) + 1) begin
      errors++; $display("FAIL %s: got %0d expected %0d +-1", e.tag, lat, e.val);
    end
    rises = (lat > 0) ? 1 : 0;
    prev  = pif.ped_req;
    repeat (20) begin
      step();
      if (pif.ped_req === 1'b1 && prev !== 1'b1) rises++;
      prev = pif.ped_req;
    end
    pif.btn_in = 1'b0;
    obs = 32'(rises); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
  endtask

  task automatic test_full_cycle();
    exp_t e;
    logic [31:0] obs;
    int lat;
    int bad;
    int ticks;
    logic prev_lk;
    apply_reset(2);
    sb.push_back(mk("pending_outs", 32'b110));
    sb.push_back(mk("serving_outs", 32'b000));
    sb.push_back(mk("serving_hold_bad_cycles", 32'd0));
    sb.push_back(mk("lockout_entry", 32'b001));
    sb.push_back(mk("lockout_ticks", 32'd3));
    sb.push_back(mk("idle_after_lockout", 32'b000));
    sb.push_back(mk("grant_in_idle_ignored", 32'b000));
    press_wait(lat);
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    pif.grant = 1'b1;
    step();
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    bad = 0;
    repeat (29) begin
      step();
      if (outs() !== 32'd0) bad++;
    end
    obs = 32'(bad); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    pif.grant = 1'b0;
    step();
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      prev_lk = pif.lockout;
      step();
      if (prev_lk === 1'b1 && pif.tick_1Hz === 1'b1) ticks++;
      if (pif.lockout !== 1'b1) break;
    end
    obs = 32'(ticks); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    pif.grant = 1'b1;
    repeat (5) step();
    pif.grant = 1'b0;
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
  endtask

  task automatic test_lockout_press();
    exp_t e;
    logic [31:0] obs;
    int lat;
    apply_reset(2);
    sb.push_back(mk("lp_in_lockout", 32'b001));
`ifdef PED_REQ_MEMORY_EN
    sb.push_back(mk("lp_memo_led", 32'b011));
    sb.push_back(mk("lp_exit_outs", 32'b110));
    sb.push_back(mk("lp_later_outs", 32'b110));
`else
    sb.push_back(mk("lp_memo_led", 32'b001));
    sb.push_back(mk("lp_exit_outs", 32'b000));
    sb.push_back(mk("lp_later_outs", 32'b000));
`endif
    press_wait(lat);
    pif.grant = 1'b1;
    repeat (3) step();
    pif.grant = 1'b0;
    repeat (2) step();
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    pif.btn_in = 1'b1;
    repeat (8) step();
    pif.btn_in = 1'b0;
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    for (int i = 0; i < 100; i++) begin
      step();
      if (pif.lockout !== 1'b1) break;
    end
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    repeat (5) step();
    obs = outs() & 32'b110; e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
  endtask

  task automatic test_blink();
    exp_t e;
    logic [31:0] obs;
    int lat;
    apply_reset(2);
    sb.push_back(mk("blink_entry", 32'd1));
    sb.push_back(mk("blink_tick1", 32'd0));
    sb.push_back(mk("blink_tick2", 32'd1));
    sb.push_back(mk("blink_tick3", 32'd0));
    sb.push_back(mk("blink_tick4", 32'd1));
    sb.push_back(mk("tie_grant_tick", 32'b000));
    press_wait(lat);
    obs = {31'd0, pif.wait_led}; e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 25; i++) begin
        step();
        if (pif.tick_1Hz === 1'b1) break;
      end
      obs = {31'd0, pif.wait_led}; e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    end
    for (int i = 0; i < 25; i++) begin
      if (tcnt == 18) break;
      step();
    end
    pif.grant = 1'b1;
    step();
    pif.grant = 1'b0;
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [31:0] obs;
    int lat;
    apply_reset(2);
    sb.push_back(mk("rst_in_pending", 32'b000));
    sb.push_back(mk("rst_repress_after_pending", 32'b110));
    sb.push_back(mk("rst_lockout_entry", 32'b001));
    sb.push_back(mk("rst_in_lockout", 32'b000));
    sb.push_back(mk("rst_repress_after_lockout", 32'b110));
    press_wait(lat);
    reset = 1'b1; step(); reset = 1'b0;
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    press_wait(lat);
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    pif.grant = 1'b1; step();
    pif.grant = 1'b0; step();
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    repeat (4) step();
    reset = 1'b1; step(); reset = 1'b0;
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    press_wait(lat);
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    logic [31:0] obs;
    apply_reset(2);
    sb.push_back(mk("sim_idle_with_grant", 32'b000));
    sb.push_back(mk("sim_pending_first", 32'b110));
    sb.push_back(mk("sim_serving_next", 32'b000));
    sb.push_back(mk("sim_lockout_after", 32'b001));
    pif.grant  = 1'b1;
    pif.btn_in = 1'b1;
    repeat (3) step();
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    for (int i = 0; i < 20; i++) begin
      step();
      if (pif.ped_req === 1'b1) break;
    end
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    step();
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
    pif.grant  = 1'b0;
    pif.btn_in = 1'b0;
    step();
    obs = outs(); e = sb.pop_front(); checks++;
    if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.tag, obs, e.val); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_full_cycle();
    test_lockout_press();
    test_blink();
    test_reset_mid();
    test_simultaneous();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
